ce_stream_unloader: RTL and testbench
=====================================

// Module: ce_stream_unloader
// PURPOSE
//   Consumer-side counterpart of a clock-enabled capture register.
//   - Accepts words that an upstream producer strobes in with CE.
//   - Buffers them in a DEPTH-entry FIFO.
//   - Presents them to a downstream consumer over a VALID/READY handshake.
//   - Sits between a CE-driven datapath stage (no backpressure) and a flow-controlled sink.
// PARAMETERS
//   WIDTH  16  data word width in bits (>=1)
//   DEPTH  4   FIFO entries; power of two, >=2
// PORTS
//   CLK       in   1      clock; all state updates on posedge
//   RESET     in   1      synchronous, active-high reset
//   I         in   WIDTH  write data, sampled when CE=1
//   CE        in   1      write strobe from producer; one word per cycle when high
//   O         out  WIDTH  head-of-FIFO data; forced to 0 when VALID=0
//   VALID     out  1      FIFO non-empty; O holds a valid word
//   READY     in   1      consumer accepts O this cycle when VALID&READY
//   FULL      out  1      count==DEPTH
//   OVERFLOW  out  1      sticky drop flag (only with CE_UNLOADER_OVF_EN)
// BEHAVIOUR
//   - State: wr_ptr, rd_ptr (log2(DEPTH) bits, wrap modulo DEPTH).
//   - count: 0..DEPTH, log2(DEPTH)+1 bits. Storage array is not reset.
//   - Reset (RESET=1 at posedge) overrides every other input that cycle:
//     ptrs=0, count=0, VALID=0, O=0, FULL=0, OVERFLOW=0.
//   - RESET mid-stream discards all buffered words.
//   - pop  = VALID & READY. On pop, rd_ptr++ at the clock edge.
//   - push = CE & (!FULL | pop). On push, mem[wr_ptr]<=I and wr_ptr++.
//   - count_next = count + push - pop. VALID = (count!=0). FULL = (count==DEPTH).
//   - Latency: word with CE at edge n -> VALID/O at cycle n+1.
//     No combinational bypass from I to O.
//   - Empty & CE & READY in the same cycle: no pop (VALID=0); word appears next cycle.
//   - Full & CE & pop: both occur, count stays DEPTH, no drop.
//   - Full & CE & !pop: incoming word dropped. FIFO contents, pointers and count unchanged.
//   - READY while VALID=0: ignored, no state change.
//   - O must stay stable while VALID=1 & READY=0.
//   - Ordering strictly FIFO; pointer wrap at DEPTH-1 -> 0 is seamless.
// CONFIGURATION
//   CE_UNLOADER_OVF_EN defined:
//     - OVERFLOW port present.
//     - Set on the edge where a word is dropped (Full & CE & !pop).
//     - Stays 1 until RESET.
//   CE_UNLOADER_OVF_EN undefined:
//     - OVERFLOW port absent; no overflow register.
//     - Drops still occur silently as above.
// TESTING
//   1. Reset: hold RESET 2 cycles with CE=1, I=16'hFFFF
//      -> VALID=0, O=0, FULL=0 after release; nothing stored.
//   2. Single word: CE=1, I=16'h1234 one cycle, READY=0
//      -> next cycle VALID=1, O=16'h1234.
//      -> READY=1 one cycle -> VALID=0, O=0.
//   3. Fill/drain: write 1,2,3,4 with READY=0 -> FULL=1.
//      -> 5th CE with I=5 dropped (OVERFLOW=1 if CE_UNLOADER_OVF_EN).
//      -> READY=1 yields 1,2,3,4 in order, then VALID=0.
//   4. Full + simultaneous CE=1 (I=9) & READY=1 -> pops head, stores 9, FULL stays 1.
//      -> drain order ends with 9, OVERFLOW stays 0.
//   5. Wrap: 10 push/pop pairs (CE=1, READY=1, I=0..9 continuous)
//      -> O sequence 0..9 at one-cycle offset, VALID held 1 after first word.
//   6. Mid-operation reset: 3 words buffered, RESET=1 with CE=1 & READY=1
//      -> next cycle VALID=0, O=0, OVERFLOW=0; the word strobed in with RESET is not stored.

Source files
------------

// File: rtl/ce_stream_unloader.sv
// ---------------------------------------------------------------------------
// ce_stream_unloader
//   Buffers words strobed in by a clock-enabled producer, which cannot be
//   stalled, in a DEPTH-entry FIFO. The words are presented to a
//   flow-controlled consumer over a VALID/READY handshake.
//
//   Parameters:
//     WIDTH    data word width in bits (>=1)
//     DEPTH    FIFO entries, power of two, >=2
//
//   Ports:
//     CLK       clock, all state updates on the rising edge
//     RESET     synchronous active-high reset, discards buffered words
//     I         write data, sampled when CE=1
//     CE        producer write strobe, one word per cycle
//     O         head-of-FIFO data, 0 whenever VALID=0 (registered)
//     VALID     FIFO non-empty (registered)
//     READY     consumer accepts O when VALID&READY
//     FULL      count==DEPTH (registered)
//     OVERFLOW  sticky drop flag, present only when CE_UNLOADER_OVF_EN is
//               defined
//
//   When the FIFO is full and no pop occurs, an incoming word is dropped.
//   The FIFO contents are not changed.
// ---------------------------------------------------------------------------
module ce_stream_unloader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             CE,
    output logic [WIDTH-1:0] O,
    output logic             VALID,
    input  logic             READY,
    output logic             FULL
`ifdef CE_UNLOADER_OVF_EN
    ,
    output logic             OVERFLOW
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;
    logic             full_r;

    logic             pop_s;
    logic             push_s;
    logic [AW-1:0]    wr_next_s;
    logic [AW-1:0]    rd_next_s;
    logic [AW:0]      count_next_s;
    logic [WIDTH-1:0] head_next_s;
`ifdef CE_UNLOADER_OVF_EN
    logic             drop_s;
    logic             ovf_r;
`endif

    // Handshake decode, next pointers/count and next head word
    always_comb begin
        pop_s        = valid_r & READY;
        push_s       = CE & (~full_r | pop_s);
        wr_next_s    = wr_ptr_r;
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        head_next_s  = {WIDTH{1'b0}};
`ifdef CE_UNLOADER_OVF_EN
        drop_s       = CE & full_r & ~pop_s;
`endif
        if (push_s) begin
            wr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        // The head is registered. When the new head slot is the one being
        // written this cycle, the word must come from I, not from mem_r.
        if (count_next_s == CNT_ZERO) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_s && (rd_next_s == wr_ptr_r)) begin
            head_next_s = I;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage array write; intentionally not reset
    always_ff @(posedge CLK) begin
        if (push_s && !RESET) begin
            mem_r[wr_ptr_r] <= I;
        end
    end

    // Pointers, occupancy and registered output flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            valid_r  <= (count_next_s != CNT_ZERO);
            full_r   <= (count_next_s == CNT_FULL);
        end
    end

`ifdef CE_UNLOADER_OVF_EN
    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | drop_s;
        end
    end

    assign OVERFLOW = ovf_r;
`endif

    assign O     = head_r;
    assign VALID = valid_r;
    assign FULL  = full_r;

endmodule

// File: tb/tb_ce_stream_unloader.sv
// ---------------------------------------------------------------------------
// tb_ce_stream_unloader
//   Directed testbench for ce_stream_unloader (WIDTH=16, DEPTH=4). The
//   inputs are driven 1 ns after each rising edge, and the outputs are
//   checked at the same point.
// ---------------------------------------------------------------------------
module tb_ce_stream_unloader;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] I;
    logic        CE;
    logic [15:0] O;
    logic        VALID;
    logic        READY;
    logic        FULL;
`ifdef CE_UNLOADER_OVF_EN
    logic        OVERFLOW;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ce_stream_unloader #(.WIDTH(16), .DEPTH(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .I        (I),
        .CE       (CE),
        .O        (O),
        .VALID    (VALID),
        .READY    (READY),
        .FULL     (FULL)
`ifdef CE_UNLOADER_OVF_EN
        ,
        .OVERFLOW (OVERFLOW)
`endif
    );

    // 100 MHz clock
    always #5 CLK = ~CLK;

    // Advance one clock and settle 1 ns past the edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef CE_UNLOADER_OVF_EN
        check(tag, {31'd0, OVERFLOW}, {31'd0, exp});
`else
        if (exp === 1'bx) begin
            $display("unused %s", tag);
        end else begin
            n_checks = n_checks + 0;
        end
`endif
    endtask

    task automatic do_reset();
        RESET = 1'b1; CE = 1'b0; READY = 1'b0; I = 16'h0000;
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        // 1. Reset held for 2 cycles while CE is strobing 16'hFFFF
        RESET = 1'b1; CE = 1'b1; I = 16'hFFFF; READY = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, VALID}, 32'd0);
        check("rst_o",     {16'd0, O},     32'd0);
        check("rst_full",  {31'd0, FULL},  32'd0);
        check_ovf("rst_ovf", 1'b0);
        RESET = 1'b0; CE = 1'b0;
        tick();
        check("rst_nothing_stored", {31'd0, VALID}, 32'd0);

        // 2. Single word, held while READY=0, then popped
        CE = 1'b1; I = 16'h1234;
        tick();
        CE = 1'b0; I = 16'h0000;
        check("single_valid", {31'd0, VALID}, 32'd1);
        check("single_o",     {16'd0, O},     32'h1234);
        tick();
        check("single_hold_o", {16'd0, O}, 32'h1234);
        READY = 1'b1;
        tick();
        READY = 1'b0;
        check("single_pop_valid", {31'd0, VALID}, 32'd0);
        check("single_pop_o",     {16'd0, O},     32'd0);

        // 3. Fill to full, drop a fifth word, then drain in order
        for (int k = 1; k <= 4; k++) begin
            CE = 1'b1; I = 16'(k);
            tick();
        end
        check("fill_full", {31'd0, FULL}, 32'd1);
        check("fill_head", {16'd0, O},    32'd1);
        check_ovf("fill_ovf_clear", 1'b0);
        I = 16'h0005;
        tick();
        CE = 1'b0;
        check("drop_full", {31'd0, FULL}, 32'd1);
        check("drop_head", {16'd0, O},    32'd1);
        check_ovf("drop_ovf_set", 1'b1);
        READY = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), {15'd0, VALID, O}, {15'd0, 1'b1, 16'(k)});
            tick();
        end
        check("drain_empty_valid", {31'd0, VALID}, 32'd0);
        check("drain_empty_o",     {16'd0, O},     32'd0);
        check("drain_empty_full",  {31'd0, FULL},  32'd0);
        check_ovf("ovf_sticky", 1'b1);
        READY = 1'b0;

        // 4. Full with a simultaneous push and pop
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            CE = 1'b1; I = 16'(k);
            tick();
        end
        I = 16'h0009; READY = 1'b1;
        tick();
        CE = 1'b0;
        check("fullpp_full", {31'd0, FULL}, 32'd1);
        check("fullpp_head", {16'd0, O},    32'd2);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] exp_w;
            exp_w = (k == 3) ? 16'h0009 : 16'(k + 2);
            check($sformatf("fullpp_drain_%0d", k), {15'd0, VALID, O}, {15'd0, 1'b1, exp_w});
            tick();
        end
        check("fullpp_empty", {31'd0, VALID}, 32'd0);
        check_ovf("fullpp_ovf_clear", 1'b0);

        // 5. Continuous push/pop across pointer wrap
        for (int k = 0; k < 10; k++) begin
            CE = 1'b1; READY = 1'b1; I = 16'(k);
            tick();
            check($sformatf("wrap_%0d", k), {15'd0, VALID, O}, {15'd0, 1'b1, 16'(k)});
            check($sformatf("wrap_nfull_%0d", k), {31'd0, FULL}, 32'd0);
        end
        CE = 1'b0;
        tick();
        READY = 1'b0;
        check("wrap_end_valid", {31'd0, VALID}, 32'd0);

        // 6. Reset with 3 words buffered and CE/READY active
        for (int k = 0; k < 3; k++) begin
            CE = 1'b1; I = 16'hA0 + 16'(k);
            tick();
        end
        check("mid_head", {15'd0, VALID, O}, {15'd0, 1'b1, 16'h00A0});
        RESET = 1'b1; CE = 1'b1; I = 16'h00DD; READY = 1'b1;
        tick();
        RESET = 1'b0; CE = 1'b0; READY = 1'b1;
        check("mid_rst_valid", {31'd0, VALID}, 32'd0);
        check("mid_rst_o",     {16'd0, O},     32'd0);
        check("mid_rst_full",  {31'd0, FULL},  32'd0);
        check_ovf("mid_rst_ovf", 1'b0);
        // READY while empty is ignored, and the word from the reset cycle is gone
        tick();
        check("mid_rst_not_stored", {31'd0, VALID}, 32'd0);
        // Push into an empty FIFO with READY=1: no pop, the word appears next cycle
        CE = 1'b1; I = 16'h0BEE;
        tick();
        CE = 1'b0; READY = 1'b0;
        check("empty_ce_ready", {15'd0, VALID, O}, {15'd0, 1'b1, 16'h0BEE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
